// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants, key map and encodings for keypad_entry
package keypad_pkg;

   localparam logic [3:0] COL0 = 4'b1110;
   localparam logic [3:0] COL1 = 4'b1101;
   localparam logic [3:0] COL2 = 4'b1011;
   localparam logic [3:0] COL3 = 4'b0111;

   localparam logic [3:0] KEY_CLR = 4'hE;
   localparam logic [3:0] KEY_ENT = 4'hF;
   localparam logic [3:0] KEY_BS  = 4'hD;

   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} db_state_t;
   typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_t;

   // pos = row*4 + col
   function automatic logic [3:0] pos_to_code(input logic [3:0] pos);
      case (pos)
         4'd0:    return 4'h1;
         4'd1:    return 4'h2;
         4'd2:    return 4'h3;
         4'd3:    return 4'hA;
         4'd4:    return 4'h4;
         4'd5:    return 4'h5;
         4'd6:    return 4'h6;
         4'd7:    return 4'hB;
         4'd8:    return 4'h7;
         4'd9:    return 4'h8;
         4'd10:   return 4'h9;
         4'd11:   return 4'hC;
         4'd12:   return 4'hE;
         4'd13:   return 4'h0;
         4'd14:   return 4'hF;
         default: return 4'hD;
      endcase
   endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// rtl/keypad_col_scan.sv - column strobe, row sync and per-frame key collection
module keypad_col_scan
   import keypad_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] i_row,
   output logic [3:0] o_col,
   output logic       frame_done,
   output frame_t     frame_result,
   output logic [3:0] frame_pos
);

   localparam int TP = CLK_HZ / SCAN_HZ;
   localparam int TW = (TP > 1) ? $clog2(TP) : 1;

   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [3:0]    row_meta;
   logic [3:0]    row_sync;
   logic [1:0]    col_idx;
   logic [1:0]    acc_hits;   // 0, 1, or 2 meaning "two or more"
   logic [3:0]    acc_pos;
   logic [2:0]    col_hits;
   logic [1:0]    hit_row;
   logic [2:0]    total_hits;
   logic [1:0]    sum_hits;
   logic [3:0]    sum_pos;

   assign tick = (tick_cnt == TW'(TP - 1));

   always_comb begin
      col_hits = '0;
      hit_row  = '0;
      for (int r = 0; r < 4; r++) begin
         if (!row_sync[r]) begin
            col_hits = col_hits + 3'd1;
            hit_row  = 2'(r);
         end
      end
      total_hits = {1'b0, acc_hits} + col_hits;
      sum_hits   = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
      sum_pos    = (acc_hits == 2'd0) ? {hit_row, col_idx} : acc_pos;
   end

   always_comb begin
      case (col_idx)
         2'd0:    o_col = COL0;
         2'd1:    o_col = COL1;
         2'd2:    o_col = COL2;
         default: o_col = COL3;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt     <= '0;
         col_idx      <= '0;
         row_meta     <= 4'hF;
         row_sync     <= 4'hF;
         acc_hits     <= '0;
         acc_pos      <= '0;
         frame_done   <= 1'b0;
         frame_result <= NONE;
         frame_pos    <= '0;
      end else begin
         row_meta   <= i_row;
         row_sync   <= row_meta;
         frame_done <= 1'b0;
         if (tick) begin
            tick_cnt <= '0;
            col_idx  <= col_idx + 2'd1;
            if (col_idx == 2'd3) begin
               frame_done <= 1'b1;
               frame_pos  <= sum_pos;
               case (sum_hits)
                  2'd0:    frame_result <= NONE;
                  2'd1:    frame_result <= SINGLE;
                  default: frame_result <= MULTI;
               endcase
               acc_hits <= '0;
               acc_pos  <= '0;
            end else begin
               acc_hits <= sum_hits;
               acc_pos  <= sum_pos;
            end
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - keypad debounce FSM and decimal value accumulator
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int CLK_HZ          = 100_000_000,
   parameter int SCAN_HZ         = 1000,
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int MAX_VALUE       = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  i_row,
   output logic [3:0]  o_col,
   output logic [13:0] o_value,
   output logic        o_key_valid,
   output logic [3:0]  o_key_code,
   output logic        o_enter,
   output logic        o_overflow
);

   localparam int              CW      = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_FRAMES);
   localparam logic [17:0]     MAX_V   = 18'(MAX_VALUE);

   logic          frame_done;
   frame_t        frame_result;
   logic [3:0]    frame_pos;

   db_state_t     state, state_n;
   logic [3:0]    cand, cand_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          accept;
   logic [3:0]    acc_code;
   logic [17:0]   value_x10;

   keypad_col_scan #(
      .CLK_HZ (CLK_HZ),
      .SCAN_HZ(SCAN_HZ)
   ) u_scan (
      .clk         (clk),
      .reset       (reset),
      .i_row       (i_row),
      .o_col       (o_col),
      .frame_done  (frame_done),
      .frame_result(frame_result),
      .frame_pos   (frame_pos)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cand  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cand  <= cand_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      accept  = 1'b0;
      if (frame_done) begin
         case (state)
            IDLE: begin
               if (frame_result == SINGLE) begin
                  cand_n = frame_pos;
                  cnt_n  = CW'(1);
                  if (cnt_n == DB_LAST) begin
                     accept  = 1'b1;
                     state_n = HELD;
                  end else begin
                     state_n = PRESS_DB;
                  end
               end
            end
            PRESS_DB: begin
               if (frame_result == SINGLE) begin
                  if (frame_pos == cand) begin
                     cnt_n = cnt + 1'b1;
                     if (cnt_n == DB_LAST) begin
                        accept  = 1'b1;
                        state_n = HELD;
                     end
                  end else begin
                     cand_n = frame_pos;
                     cnt_n  = CW'(1);
                  end
               end else begin
                  state_n = IDLE;
               end
            end
            HELD: begin
               if (frame_result == NONE) begin
                  cnt_n   = CW'(1);
                  state_n = (cnt_n == DB_LAST) ? IDLE : REL_DB;
               end
            end
            default: begin
               if (frame_result == NONE) begin
                  cnt_n = cnt + 1'b1;
                  if (cnt_n == DB_LAST) state_n = IDLE;
               end else begin
                  state_n = HELD;
               end
            end
         endcase
      end
   end

   // cand_n holds the accepted position on the accepting cycle
   always_comb begin
      acc_code  = pos_to_code(cand_n);
      value_x10 = {4'b0, o_value} * 18'd10 + {14'b0, acc_code};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_value     <= '0;
         o_key_valid <= 1'b0;
         o_key_code  <= '0;
         o_enter     <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         o_key_valid <= accept;
         o_enter     <= 1'b0;
         o_overflow  <= 1'b0;
         if (accept) begin
            o_key_code <= acc_code;
            if (acc_code <= 4'd9) begin
               if (value_x10 <= MAX_V) o_value <= value_x10[13:0];
               else                    o_overflow <= 1'b1;
            end else begin
               case (acc_code)
                  KEY_CLR: o_value <= '0;
                  KEY_BS:  o_value <= o_value / 14'd10;
                  KEY_ENT: o_enter <= 1'b1;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - directed self-checking bench for keypad_entry
module tb_keypad_entry;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  i_row;
   logic [3:0]  o_col;
   logic [13:0] o_value;
   logic        o_key_valid;
   logic [3:0]  o_key_code;
   logic        o_enter;
   logic        o_overflow;

   logic [15:0] keys = '0;
   int passed = 0;
   int total  = 0;
   int kv_count  = 0;
   int ent_count = 0;
   int ovf_count = 0;

   keypad_entry #(
      .CLK_HZ(40), .SCAN_HZ(10), .DEBOUNCE_FRAMES(2), .MAX_VALUE(9999)
   ) dut (
      .clk(clk), .reset(reset), .i_row(i_row), .o_col(o_col),
      .o_value(o_value), .o_key_valid(o_key_valid), .o_key_code(o_key_code),
      .o_enter(o_enter), .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   // key at pos row*4+col pulls its row low while its column strobe is low
   always_comb begin
      i_row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !o_col[c]) i_row[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (o_key_valid) kv_count++;
      if (o_enter)     ent_count++;
      if (o_overflow)  ovf_count++;
   end

   task automatic wait_frames(input int n);
      repeat (n * 16) @(negedge clk);
   endtask

   task automatic press(input logic [15:0] mask, input int hold, input int rel);
      keys = keys | mask;
      wait_frames(hold);
      keys = keys & ~mask;
      wait_frames(rel);
   endtask

   task automatic test_reset;
      int n;
      repeat (3) @(negedge clk);
      total++; if (o_col !== 4'b1110) $display("FAIL reset_col got %b want 1110", o_col); else passed++;
      total++; if (o_value !== 14'd0) $display("FAIL reset_value got %0d want 0", o_value); else passed++;
      total++; if (o_key_code !== 4'd0) $display("FAIL reset_code got %h want 0", o_key_code); else passed++;
      total++; if ({o_key_valid, o_enter, o_overflow} !== 3'b000)
         $display("FAIL reset_pulses got %b want 000", {o_key_valid, o_enter, o_overflow}); else passed++;
      reset = 1'b1;
      n = 0;
      while (o_col === 4'b1110 && n < 8) begin @(negedge clk); n++; end
      total++; if (n !== 4) $display("FAIL first_tick_cycles got %0d want 4", n); else passed++;
      total++; if (o_col !== 4'b1101) $display("FAIL col_step1 got %b want 1101", o_col); else passed++;
      repeat (4) @(negedge clk);
      total++; if (o_col !== 4'b1011) $display("FAIL col_step2 got %b want 1011", o_col); else passed++;
      repeat (4) @(negedge clk);
      total++; if (o_col !== 4'b0111) $display("FAIL col_step3 got %b want 0111", o_col); else passed++;
      repeat (4) @(negedge clk);
      total++; if (o_col !== 4'b1110) $display("FAIL col_step4 got %b want 1110", o_col); else passed++;
   endtask

   task automatic test_digits;
      logic [3:0]  pos_tbl  [4] = '{4'd0, 4'd1, 4'd2, 4'd4};
      logic [3:0]  code_tbl [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
      logic [13:0] val_tbl  [4] = '{14'd1, 14'd12, 14'd123, 14'd1234};
      int kv0;
      for (int i = 0; i < 4; i++) begin
         kv0 = kv_count;
         press(16'(1) << pos_tbl[i], 5, 5);
         total++; if (kv_count - kv0 !== 1) $display("FAIL digit%0d_pulses got %0d want 1", i, kv_count - kv0); else passed++;
         total++; if (o_key_code !== code_tbl[i]) $display("FAIL digit%0d_code got %h want %h", i, o_key_code, code_tbl[i]); else passed++;
         total++; if (o_value !== val_tbl[i]) $display("FAIL digit%0d_value got %0d want %0d", i, o_value, val_tbl[i]); else passed++;
      end
   endtask

   task automatic test_edit_keys;
      int kv0, ov0, en0;
      kv0 = kv_count; ov0 = ovf_count;
      press(16'(1) << 5, 5, 5);
      total++; if (ovf_count - ov0 !== 1) $display("FAIL overflow_pulse got %0d want 1", ovf_count - ov0); else passed++;
      total++; if (kv_count - kv0 !== 1) $display("FAIL overflow_kv got %0d want 1", kv_count - kv0); else passed++;
      total++; if (o_value !== 14'd1234) $display("FAIL overflow_value got %0d want 1234", o_value); else passed++;
      press(16'(1) << 15, 5, 5);
      total++; if (o_value !== 14'd123) $display("FAIL backspace_value got %0d want 123", o_value); else passed++;
      total++; if (o_key_code !== 4'hD) $display("FAIL backspace_code got %h want d", o_key_code); else passed++;
      press(16'(1) << 12, 5, 5);
      total++; if (o_value !== 14'd0) $display("FAIL clear_value got %0d want 0", o_value); else passed++;
      en0 = ent_count; kv0 = kv_count;
      press(16'(1) << 14, 5, 5);
      total++; if (ent_count - en0 !== 1) $display("FAIL enter_pulse got %0d want 1", ent_count - en0); else passed++;
      total++; if (o_value !== 14'd0) $display("FAIL enter_value got %0d want 0", o_value); else passed++;
      total++; if (o_key_code !== 4'hF) $display("FAIL enter_code got %h want f", o_key_code); else passed++;
      total++; if (kv_count - kv0 !== 1) $display("FAIL enter_kv got %0d want 1", kv_count - kv0); else passed++;
   endtask

   task automatic test_bounce;
      int kv0;
      kv0 = kv_count;
      press(16'(1) << 8, 1, 5);
      total++; if (kv_count - kv0 !== 0) $display("FAIL bounce_pulses got %0d want 0", kv_count - kv0); else passed++;
      total++; if (o_value !== 14'd0) $display("FAIL bounce_value got %0d want 0", o_value); else passed++;
      kv0 = kv_count;
      press(16'(1) << 8, 40, 5);
      total++; if (kv_count - kv0 !== 1) $display("FAIL long_hold_pulses got %0d want 1", kv_count - kv0); else passed++;
      total++; if (o_value !== 14'd7) $display("FAIL long_hold_value got %0d want 7", o_value); else passed++;
   endtask

   task automatic test_multi;
      int kv0;
      kv0 = kv_count;
      press((16'(1) << 0) | (16'(1) << 5), 5, 5);
      total++; if (kv_count - kv0 !== 0) $display("FAIL multi_pulses got %0d want 0", kv_count - kv0); else passed++;
      total++; if (o_value !== 14'd7) $display("FAIL multi_value got %0d want 7", o_value); else passed++;
      kv0 = kv_count;
      keys = 16'(1) << 5;
      wait_frames(5);
      keys = keys | (16'(1) << 10);
      wait_frames(5);
      keys = '0;
      wait_frames(5);
      total++; if (kv_count - kv0 !== 1) $display("FAIL held_second_key_pulses got %0d want 1", kv_count - kv0); else passed++;
      total++; if (o_value !== 14'd75) $display("FAIL held_second_key_value got %0d want 75", o_value); else passed++;
      kv0 = kv_count;
      press(16'(1) << 12, 5, 5);
      total++; if (kv_count - kv0 !== 1) $display("FAIL after_multi_idle got %0d want 1", kv_count - kv0); else passed++;
      total++; if (o_value !== 14'd0) $display("FAIL after_multi_value got %0d want 0", o_value); else passed++;
   endtask

   task automatic test_reset_mid;
      int kv0, n;
      press(16'(1) << 9, 5, 5);
      total++; if (o_value !== 14'd8) $display("FAIL pre_reset_value got %0d want 8", o_value); else passed++;
      n = 0;
      while (o_col !== 4'b0111 && n < 20) begin @(negedge clk); n++; end
      while (o_col !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
      total++; if (n >= 40) $display("FAIL frame_align_timeout got %0d want <40", n); else passed++;
      kv0 = kv_count;
      keys = 16'(1) << 2;
      repeat (20) @(negedge clk);
      total++; if (kv_count - kv0 !== 0) $display("FAIL press_db_no_pulse got %0d want 0", kv_count - kv0); else passed++;
      reset = 1'b0;
      @(negedge clk);
      total++; if (o_col !== 4'b1110) $display("FAIL midreset_col got %b want 1110", o_col); else passed++;
      total++; if (o_value !== 14'd0) $display("FAIL midreset_value got %0d want 0", o_value); else passed++;
      total++; if (o_key_code !== 4'd0) $display("FAIL midreset_code got %h want 0", o_key_code); else passed++;
      keys = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wait_frames(5);
      total++; if (kv_count - kv0 !== 0) $display("FAIL postreset_pulses got %0d want 0", kv_count - kv0); else passed++;
      total++; if (o_value !== 14'd0) $display("FAIL postreset_value got %0d want 0", o_value); else passed++;
   endtask

   initial begin
      test_reset();
      test_digits();
      test_edit_keys();
      test_bounce();
      test_multi();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
